// File: rtl/w_engine_pkg.sv
// +------------------------------------------------------------------+
// | w_engine_pkg : shared types for the AXI4 write-data stage         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package w_engine_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_LEN = 2'd1,
    S_SEND_W   = 2'd2,
    S_AW_WAIT  = 2'd3
  } WState_t;

  localparam int LEN_W       = 8;
  localparam int LEN_ENTRY_W = LEN_W + 1;

  typedef struct packed {
    logic             last;
    logic [LEN_W-1:0] len;
  } len_entry_t;

  function automatic int beat_bytes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_w_if.sv
// +------------------------------------------------------------------+
// | AXI4_W : AXI4 write-data channel bundle                           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface AXI4_W #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  modport master (output wdata, output wstrb, output wlast, output wvalid, input wready);
  modport slave  (input wdata, input wstrb, input wlast, input wvalid, output wready);
endinterface

`default_nettype wire

// File: rtl/w_engine_len_fifo.sv
// +------------------------------------------------------------------+
// | len_fifo : small synchronous FIFO holding issued AW burst lengths |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module len_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + 1'b1;
      if (w_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/w_engine.sv
// +------------------------------------------------------------------+
// | w_engine : AXI4 W-channel stage, streams beats for each AW burst  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module w_engine
  import w_engine_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BTT_WIDTH      = 32,
  parameter int LEN_FIFO_DEPTH = 4,
  parameter int SYNC_AW_W      = 0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [BTT_WIDTH-1:0]      btt,
  input  logic                      write_zero,
  input  logic                      aw_new_transaction,
  input  logic [7:0]                aw_len,
  input  logic                      aw_last,
  output logic                      aw_enable,
  input  logic [AXI_DATA_WIDTH-1:0] fifo_dout,
  input  logic                      fifo_empty,
  output logic                      fifo_rd,
  input  logic                      aw_sync,
  output logic                      w_sync,
  output logic                      done,
  AXI4_W.master                     w_chan
);

  localparam int BYTES_PER_BEAT = beat_bytes(AXI_DATA_WIDTH);
  localparam int OFFS_W         = (BYTES_PER_BEAT > 1) ? $clog2(BYTES_PER_BEAT) : 1;

  WState_t             state_q;
  logic [LEN_W-1:0]    cnt_q;
  logic                last_q;
  logic                wz_q;
  logic [OFFS_W-1:0]   rem_q;

  logic [OFFS_W-1:0]   w_rem_in;
  logic                w_unused_btt;
  len_entry_t          w_head;
  logic [LEN_ENTRY_W-1:0] w_head_raw;
  logic                w_len_empty;
  logic                w_len_full;
  logic                w_len_pop;
  logic                w_wvalid;
  logic                w_wlast;
  logic                w_hs;
  logic                w_burst_end;
  logic [BYTES_PER_BEAT-1:0] w_tail_strb;

  // Only the sub-beat remainder of btt matters: the aligned start makes every
  // beat full except possibly the very last one.
  generate
    if (BYTES_PER_BEAT > 1) begin : g_rem
      assign w_rem_in = btt[OFFS_W-1:0];
    end else begin : g_rem_none
      assign w_rem_in = '0;
    end
  endgenerate
  assign w_unused_btt = ^btt;

  len_fifo #(
    .WIDTH (LEN_ENTRY_W),
    .DEPTH (LEN_FIFO_DEPTH)
  ) u_len_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (aw_new_transaction),
    .din_i   ({aw_last, aw_len}),
    .pop_i   (w_len_pop),
    .dout_o  (w_head_raw),
    .full_o  (w_len_full),
    .empty_o (w_len_empty)
  );

  assign w_head      = len_entry_t'(w_head_raw);
  assign aw_enable   = !w_len_full;
  assign w_len_pop   = (state_q == S_WAIT_LEN) && !w_len_empty;

  assign w_wvalid    = (state_q == S_SEND_W) && (wz_q || !fifo_empty);
  assign w_wlast     = (state_q == S_SEND_W) && (cnt_q == '0);
  assign w_hs        = w_wvalid && w_chan.wready;
  assign w_burst_end = w_hs && w_wlast;
  assign w_tail_strb = (rem_q == '0) ? '1 : ~({BYTES_PER_BEAT{1'b1}} << rem_q);

  assign w_chan.wvalid = w_wvalid;
  assign w_chan.wlast  = w_wlast;
  assign w_chan.wdata  = wz_q ? '0 : fifo_dout;
  assign w_chan.wstrb  = (w_wlast && last_q) ? w_tail_strb : '1;

  assign fifo_rd = w_hs && !wz_q;
  assign done    = w_burst_end && last_q;
  assign w_sync  = (SYNC_AW_W != 0) && (w_burst_end || (state_q == S_AW_WAIT));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      wz_q    <= 1'b0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_q   <= w_rem_in;
            wz_q    <= write_zero;
            state_q <= S_WAIT_LEN;
          end
        end
        S_WAIT_LEN: begin
          if (!w_len_empty) begin
            cnt_q   <= w_head.len;
            last_q  <= w_head.last;
            state_q <= S_SEND_W;
          end
        end
        S_SEND_W: begin
          if (w_hs) begin
            if (cnt_q == '0) begin
              if (last_q)                              state_q <= S_IDLE;
              else if ((SYNC_AW_W != 0) && !aw_sync)   state_q <= S_AW_WAIT;
              else                                     state_q <= S_WAIT_LEN;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        S_AW_WAIT: begin
          if (aw_sync) state_q <= S_WAIT_LEN;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_w_engine.sv
// +------------------------------------------------------------------+
// | tb_w_engine : scoreboard bench for w_engine                       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_w_engine;

  localparam int DW    = 64;
  localparam int BTT_W = 16;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  strb;
    bit          last;
    bit          done;
    bit          rd;
  } beat_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [BTT_W-1:0] btt;
  logic             write_zero;
  logic             aw_new_transaction;
  logic [7:0]       aw_len;
  logic             aw_last;
  logic             aw_enable;
  logic [DW-1:0]    fifo_dout;
  logic             fifo_empty;
  logic             fifo_rd;
  logic             aw_sync;
  logic             w_sync;
  logic             done;

  AXI4_W #(.DATA_WIDTH(DW)) w_if ();

  w_engine #(
    .AXI_DATA_WIDTH (DW),
    .BTT_WIDTH      (BTT_W),
    .LEN_FIFO_DEPTH (4),
    .SYNC_AW_W      (1)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .start              (start),
    .btt                (btt),
    .write_zero         (write_zero),
    .aw_new_transaction (aw_new_transaction),
    .aw_len             (aw_len),
    .aw_last            (aw_last),
    .aw_enable          (aw_enable),
    .fifo_dout          (fifo_dout),
    .fifo_empty         (fifo_empty),
    .fifo_rd            (fifo_rd),
    .aw_sync            (aw_sync),
    .w_sync             (w_sync),
    .done               (done),
    .w_chan             (w_if.master)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  beat_t       sb[$];
  logic [63:0] wq[$];
  logic [63:0] data_ctr = 64'hA5A5_0000_0000_0001;
  int          btt_cur = 0;
  bit          wz_cur = 0;
  bit          rd_seen = 0;
  bit          rdy_mode = 0;
  bit          rdy_val = 0;
  bit          gap_mode = 0;
  bit          hold_empty = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Writer FIFO model and channel back-pressure, updated just after each edge.
  initial begin
    w_if.wready = 1'b0;
    fifo_empty  = 1'b1;
    fifo_dout   = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rd_seen && wq.size() > 0) void'(wq.pop_front());
      w_if.wready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
      fifo_empty  = hold_empty || (wq.size() == 0) || (gap_mode && ($urandom_range(0, 3) == 0));
      fifo_dout   = (wq.size() > 0) ? wq[0] : 64'd0;
    end
  end

  always @(negedge clk) begin
    rd_seen = 1'b0;
    if (rstn === 1'b1) begin
      if (w_if.wvalid && w_if.wready) begin
        if (sb.size() == 0) begin
          chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("wdata", w_if.wdata, e.data);
          chk("wstrb", 64'(w_if.wstrb), 64'(e.strb));
          chk("wlast", 64'(w_if.wlast), 64'(e.last));
          chk("done",  64'(done), 64'(e.done));
          chk("fifo_rd", 64'(fifo_rd), 64'(e.rd));
          chk("w_sync", 64'(w_sync), 64'(e.last));
        end
        rd_seen = fifo_rd;
      end else begin
        if (done)    chk("done_no_hs", 64'(done), 64'd0);
        if (fifo_rd) chk("rd_no_hs", 64'(fifo_rd), 64'd0);
      end
    end
  end

  task automatic plan_burst(input int len, input bit last);
    for (int i = 0; i <= len; i++) begin
      beat_t b;
      int    r;
      r = btt_cur % 8;
      b.data = wz_cur ? 64'd0 : data_ctr;
      if (!wz_cur) begin
        wq.push_back(data_ctr);
        data_ctr = data_ctr + 64'h0000_0001_0000_0003;
      end
      b.last = (i == len);
      b.done = last && (i == len);
      b.strb = (b.done && r != 0) ? (8'hFF >> (8 - r)) : 8'hFF;
      b.rd   = !wz_cur;
      sb.push_back(b);
    end
  endtask

  task automatic aw_push(input int len, input bit last);
    int t = 0;
    @(negedge clk);
    while (!aw_enable && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("aw_enable_before_push", 64'(aw_enable), 64'd1);
    @(posedge clk); #1;
    aw_new_transaction = 1'b1;
    aw_len             = 8'(len);
    aw_last            = last;
    @(posedge clk); #1;
    aw_new_transaction = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk); #1;
    start      = 1'b1;
    btt        = BTT_W'(btt_cur);
    write_zero = wz_cur;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic drain(input string tag, input int max);
    int t = 0;
    while (sb.size() != 0 && t < max) begin
      @(negedge clk);
      t++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; start = 1'b0; btt = '0; write_zero = 1'b0;
    aw_new_transaction = 1'b0; aw_len = '0; aw_last = 1'b0; aw_sync = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_wvalid", 64'(w_if.wvalid), 64'd0);
    chk("rst_fifo_rd", 64'(fifo_rd), 64'd0);
    chk("rst_w_sync", 64'(w_sync), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_aw_enable", 64'(aw_enable), 64'd1);

    // 256 bytes, one 32-beat burst, full strobes throughout.
    rdy_val = 1; btt_cur = 256; wz_cur = 0;
    plan_burst(31, 1);
    aw_push(31, 1);
    do_start();
    drain("drain_256", 200);

    // 13 bytes: tail strobe keeps only 5 bytes.
    btt_cur = 13;
    plan_burst(1, 1);
    aw_push(1, 1);
    do_start();
    drain("drain_13", 50);

    // Write-zero with the writer FIFO held empty.
    hold_empty = 1; btt_cur = 32; wz_cur = 1;
    plan_burst(3, 1);
    aw_push(3, 1);
    do_start();
    drain("drain_zero", 50);
    hold_empty = 0; wz_cur = 0;

    // Fill the length FIFO while the channel is stalled.
    rdy_val = 0; btt_cur = 80;
    for (int k = 0; k < 4; k++) begin
      plan_burst(1, 0);
      aw_push(1, 0);
    end
    @(negedge clk);
    chk("len_full", 64'(aw_enable), 64'd0);
    do_start();
    @(negedge clk);
    chk("full_during_pop", 64'(aw_enable), 64'd0);
    @(negedge clk);
    chk("rise_after_pop", 64'(aw_enable), 64'd1);
    chk("stall_wvalid", 64'(w_if.wvalid), 64'd1);
    plan_burst(1, 1);
    aw_push(1, 1);
    rdy_val = 1;
    drain("drain_depth", 300);

    // AW/W rendezvous: hold in AW_WAIT until aw_sync arrives.
    aw_sync = 0; btt_cur = 32;
    plan_burst(1, 0);
    plan_burst(1, 1);
    aw_push(1, 0);
    aw_push(1, 1);
    do_start();
    begin
      int t = 0;
      while (sb.size() > 2 && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("first_burst_done", 64'(sb.size()), 64'd2);
    end
    repeat (3) begin
      @(negedge clk);
      chk("aw_wait_sync", 64'(w_sync), 64'd1);
      chk("aw_wait_valid", 64'(w_if.wvalid), 64'd0);
    end
    @(posedge clk); #1 aw_sync = 1;
    @(posedge clk); #1 aw_sync = 0;
    @(negedge clk);
    chk("wait_len_sync", 64'(w_sync), 64'd0);
    chk("wait_len_valid", 64'(w_if.wvalid), 64'd0);
    @(negedge clk);
    chk("resume_valid", 64'(w_if.wvalid), 64'd1);
    aw_sync = 1;
    drain("drain_sync", 100);

    // Random back-pressure and FIFO gaps, then a mid-burst reset.
    rdy_mode = 1; gap_mode = 1; btt_cur = 200;
    for (int k = 0; k < 3; k++) plan_burst(7, 0);
    plan_burst(0, 1);
    do_start();
    for (int k = 0; k < 3; k++) aw_push(7, 0);
    aw_push(0, 1);
    begin
      int t = 0;
      while (sb.size() > 14 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      chk("pre_reset_progress", 64'(sb.size() <= 14), 64'd1);
    end
    rdy_mode = 0; rdy_val = 0; gap_mode = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    sb.delete();
    wq.delete();
    @(negedge clk);
    chk("post_rst_wvalid", 64'(w_if.wvalid), 64'd0);
    chk("post_rst_aw_enable", 64'(aw_enable), 64'd1);
    chk("post_rst_done", 64'(done), 64'd0);
    chk("post_rst_w_sync", 64'(w_sync), 64'd0);
    rdy_mode = 1; gap_mode = 1; btt_cur = 28;
    plan_burst(3, 1);
    aw_push(3, 1);
    do_start();
    drain("drain_after_rst", 300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
